wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 22 ++
 rtl/wb_arbiter_rr_select.sv | 35 +++
 rtl/wb_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the Wishbone round-robin arbiter: FSM encoding and the
// bus control signal group.
package wb_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Control signal group driven towards the slave.
  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
  } wb_ctrl_t;

  // Width of a master index; never below one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after `last`, wrapping
// modulo N. Returns both a one-hot vector and the winning index.
module rr_select
  import wb_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  int   pos;
  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // the block leaves a value held over -- otherwise a latch is inferred.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!found && req[IW'(pos)]) begin
        found              = 1'b1;
        onehot[IW'(pos)]   = 1'b1;
        idx                = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone N-master to 1-slave round-robin arbiter with registered grant.
// Define WB_ARBITER_TIMEOUT_EN to abort slave stalls after TIMEOUT cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int MASTERS    = 2,
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = idx_width(MASTERS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MASTERS-1:0]           m_cyc,
  input  logic [MASTERS-1:0]           m_stb,
  input  logic [MASTERS-1:0]           m_we,
  input  logic [ADDR_WIDTH*MASTERS-1:0] m_addr,
  input  logic [DATA_WIDTH*MASTERS-1:0] m_data_write,
  output logic [MASTERS-1:0]           m_ack,
  output logic [MASTERS-1:0]           m_err,
  output logic [DATA_WIDTH-1:0]        m_data_read,
  output logic                         s_cyc,
  output logic                         s_stb,
  output logic                         s_we,
  output logic [ADDR_WIDTH-1:0]        s_addr,
  output logic [DATA_WIDTH-1:0]        s_data_write,
  input  logic                         s_ack,
  input  logic                         s_err,
  input  logic [DATA_WIDTH-1:0]        s_data_read,
  output logic [MASTERS-1:0]           grant
);

  state_t               state, state_next;
  logic [MASTERS-1:0]   grant_next;
  logic [IW-1:0]        last_grant, last_next;
  logic [MASTERS-1:0]   sel_onehot;
  logic [IW-1:0]        sel_idx;
  logic                 gnt_cyc, gnt_stb, gnt_we;
  logic                 timeout_fire;
  wb_ctrl_t             s_ctrl;

  rr_select #(.N(MASTERS)) u_rr_select (
    .req    (m_cyc),
    .last   (last_grant),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(MASTERS - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_next = BUSY;
          grant_next = sel_onehot;
          last_next  = sel_idx;
        end
      end
      BUSY: begin
        // Grant is never preempted; only the owner releasing cyc ends it.
        if (!gnt_cyc) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Grant is all-zero in IDLE, so this AND-OR mux also parks the slave side.
  assign gnt_cyc = |(grant & m_cyc);
  assign gnt_stb = |(grant & m_stb);
  assign gnt_we  = |(grant & m_we);

  always_comb begin
    s_addr       = '0;
    s_data_write = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (grant[i]) begin
        s_addr       = s_addr       | m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_data_write = s_data_write | m_data_write[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;
  logic          stall;

  assign stall        = (state == BUSY) && gnt_stb && !s_ack && !s_err;
  assign timeout_fire = stall && (stall_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state != BUSY || !gnt_cyc || timeout_fire || s_ack || s_err) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_fire   = 1'b0;
`endif

  // The abort cycle hides the strobe from the slave and reports an error.
  assign s_ctrl = '{cyc: gnt_cyc, stb: gnt_stb & ~timeout_fire, we: gnt_we};
  assign s_cyc  = s_ctrl.cyc;
  assign s_stb  = s_ctrl.stb;
  assign s_we   = s_ctrl.we;

  assign m_ack       = grant & {MASTERS{s_ack & ~timeout_fire}};
  assign m_err       = grant & {MASTERS{s_err | timeout_fire}};
  assign m_data_read = s_data_read;

endmodule
